// File: rtl/mmio_bridge.sv
// Data-side MMIO bridge: decodes DM / two timers / interrupt-responder windows,
// muxes read data combinationally and builds the HWInt vector for CP0.

module mmio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  woff,
    input  logic [31:0] wdata,
    output logic [3:0]  ctrl,
    output logic [31:0] preset,
    output logic [31:0] count,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t state;
    logic   irq_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (ctrl[0]) state <= S_LOAD;
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= S_INT;
                    end
                end
                S_INT: begin
                    // Mode 1 auto-reloads (En stays set); every other mode is one-shot.
                    if (ctrl[2:1] == 2'd1) irq_flag <= 1'b0;
                    else                   ctrl[0]  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Placed after the FSM so a CPU CTRL write overrides the FSM's En clear.
            if (we && woff == 2'd0) begin
                ctrl     <= wdata[3:0];
                irq_flag <= 1'b0;
            end else if (we && woff == 2'd1) begin
                preset <= wdata;
            end
        end
    end

    assign irq = irq_flag & ctrl[3];
endmodule

module mmio_bridge #(
    parameter logic [31:0] DM_TOP   = 32'h0000_2fff,
    parameter logic [31:0] TC0_BASE = 32'h0000_7f00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7f10,
    parameter logic [31:0] INT_BASE = 32'h0000_7f20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata,
    input  logic        ext_irq,
    output logic        int_ack,
    output logic [5:0]  HWInt
);
    localparam logic [1:0][31:0] TC_BASE = {TC1_BASE, TC0_BASE};

    logic            dm_hit;
    logic            int_hit;
    logic [1:0]      tc_hit;
    logic [1:0][3:0] tc_ctrl;
    logic [1:0][31:0] tc_preset;
    logic [1:0][31:0] tc_count;
    logic [1:0]      tc_irq;

    assign dm_hit  = (m_data_addr <= DM_TOP);
    assign int_hit = (m_data_addr >= INT_BASE) && (m_data_addr < INT_BASE + 32'd4);

    assign dm_addr   = m_data_addr;
    assign dm_wdata  = m_data_wdata;
    assign dm_byteen = dm_hit ? m_data_byteen : 4'b0000;
    assign int_ack   = int_hit && (m_data_byteen != 4'b0000);
    assign HWInt     = {3'b000, ext_irq, tc_irq[1], tc_irq[0]};

    // Timer bases are 16-byte aligned, so addr[3:2] is the register index.
    for (genvar i = 0; i < 2; i++) begin : g_tc
        assign tc_hit[i] = (m_data_addr >= TC_BASE[i]) && (m_data_addr < TC_BASE[i] + 32'd12);

        mmio_timer u_tc (
            .clk    (clk),
            .reset  (reset),
            .we     (tc_hit[i] && (m_data_byteen == 4'b1111)),
            .woff   (m_data_addr[3:2]),
            .wdata  (m_data_wdata),
            .ctrl   (tc_ctrl[i]),
            .preset (tc_preset[i]),
            .count  (tc_count[i]),
            .irq    (tc_irq[i])
        );
    end

    always_comb begin
        m_data_rdata = '0;
        if (dm_hit) m_data_rdata = dm_rdata;
        for (int i = 0; i < 2; i++) begin
            if (tc_hit[i]) begin
                case (m_data_addr[3:2])
                    2'd0:    m_data_rdata = {28'd0, tc_ctrl[i]};
                    2'd1:    m_data_rdata = tc_preset[i];
                    2'd2:    m_data_rdata = tc_count[i];
                    default: m_data_rdata = '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: a decode vector table plus hand-timed
// timer sequences (mode 0, mode 1, masking, illegal writes, reset mid-count).

module tb_mmio_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  byteen, dm_byteen;
    logic        ext_irq, int_ack;
    logic [5:0]  hwint;

    int checks = 0;
    int errors = 0;

    mmio_bridge dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (addr),
        .m_data_wdata  (wdata),
        .m_data_byteen (byteen),
        .m_data_rdata  (rdata),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_byteen     (dm_byteen),
        .dm_rdata      (dm_rdata),
        .ext_irq       (ext_irq),
        .int_ack       (int_ack),
        .HWInt         (hwint)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        ext;
        logic [31:0] e_rdata;
        logic [3:0]  e_dmbe;
        logic        e_ack;
        logic [5:0]  e_hw;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a write now (caller is away from the edge), hold across one rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; byteen = be;
        @(posedge clk);
        #1 byteen = 4'b0000;
    endtask

    initial begin
        // addr, wdata, byteen, ext, rdata, dm_byteen, int_ack, HWInt  (dm_rdata = deadbeef)
        vecs[0]  = '{32'h7f00, 32'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[1]  = '{32'h7f04, 32'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[2]  = '{32'h7f08, 32'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[3]  = '{32'h7f10, 32'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[4]  = '{32'h7f14, 32'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[5]  = '{32'h7f18, 32'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[6]  = '{32'h0010, 32'h12345678, 4'h3, 1'b0, 32'hdeadbeef, 4'h3, 1'b0, 6'h00};
        vecs[7]  = '{32'h3000, 32'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[8]  = '{32'h3000, 32'h1, 4'hf, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[9]  = '{32'h2ffc, 32'h0, 4'hf, 1'b0, 32'hdeadbeef, 4'hf, 1'b0, 6'h00};
        vecs[10] = '{32'h7f0c, 32'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[11] = '{32'h7f20, 32'h5, 4'hf, 1'b0, 32'h0,        4'h0, 1'b1, 6'h00};
        vecs[12] = '{32'h7f24, 32'h5, 4'hf, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[13] = '{32'h7f20, 32'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 6'h00};
        vecs[14] = '{32'h0000, 32'h0, 4'h8, 1'b1, 32'hdeadbeef, 4'h8, 1'b0, 6'h04};

        reset = 1'b1; addr = '0; wdata = '0; byteen = '0; ext_irq = 1'b0; dm_rdata = 32'hdeadbeef;

        // Reset: combinational routing still works while reset is held.
        @(posedge clk); @(negedge clk);
        addr = 32'h10; byteen = 4'hf; #1;
        chk("dm_byteen_in_reset", {28'd0, dm_byteen}, 32'hf);
        chk("hwint_in_reset", {26'd0, hwint}, 32'h0);
        byteen = 4'h0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;

        // Decode / reset-state table.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            addr = vecs[i].a; wdata = vecs[i].d; byteen = vecs[i].be; ext_irq = vecs[i].ext;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rdata);
            chk($sformatf("vec%0d_dm_byteen", i), {28'd0, dm_byteen}, {28'd0, vecs[i].e_dmbe});
            chk($sformatf("vec%0d_int_ack", i), {31'd0, int_ack}, {31'd0, vecs[i].e_ack});
            chk($sformatf("vec%0d_hwint", i), {26'd0, hwint}, {26'd0, vecs[i].e_hw});
        end
        chk("dm_addr_passthru", dm_addr, 32'h0);
        @(negedge clk);
        byteen = 4'h0; ext_irq = 1'b0; wdata = 32'ha5a5_5a5a; #1;
        chk("dm_wdata_passthru", dm_wdata, 32'ha5a5_5a5a);

        // TC0 mode 0, PRESET 5: COUNT 5..1 after edges W+2..W+6, IRQ at W+7 and held.
        wr(32'h7f04, 32'd5, 4'hf);
        wr(32'h7f00, 32'h9, 4'hf);
        addr = 32'h7f08;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); @(negedge clk);
            if (k >= 2 && k <= 6) chk($sformatf("tc0_count_k%0d", k), rdata, 32'(7 - k));
            chk($sformatf("tc0_irq_k%0d", k), {31'd0, hwint[0]}, (k >= 7) ? 32'd1 : 32'd0);
        end
        chk("tc0_count_end", rdata, 32'd0);
        addr = 32'h7f00; #1;
        chk("tc0_ctrl_after_oneshot", rdata, 32'h8);
        wr(32'h7f00, 32'h0, 4'hf);
        @(negedge clk);
        chk("tc0_irq_cleared", {31'd0, hwint[0]}, 32'd0);

        // TC1 mode 1, PRESET 3: one-cycle pulse at W+5, W+11, W+17.
        wr(32'h7f14, 32'd3, 4'hf);
        wr(32'h7f10, 32'hb, 4'hf);
        addr = 32'h7f18;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("tc1_pulse_k%0d", k), {31'd0, hwint[1]},
                (k >= 5 && (k - 5) % 6 == 0) ? 32'd1 : 32'd0);
        end
        // Mask IRQ at edge W+19 while the timer keeps reloading.
        wr(32'h7f10, 32'h3, 4'hf);
        addr = 32'h7f18;
        for (int k = 20; k <= 26; k++) begin
            logic [31:0] exp_cnt [7];
            exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd3};
            @(posedge clk); @(negedge clk);
            chk($sformatf("tc1_masked_count_k%0d", k), rdata, exp_cnt[k - 20]);
            chk($sformatf("tc1_masked_irq_k%0d", k), {31'd0, hwint[1]}, 32'd0);
        end
        wr(32'h7f10, 32'h0, 4'hf);

        // Illegal writes: COUNT is read-only, partial writes to timer regs are dropped.
        wr(32'h7f08, 32'hffff, 4'hf);
        addr = 32'h7f08; @(negedge clk);
        chk("count_write_ignored", rdata, 32'd0);
        wr(32'h7f00, 32'hf, 4'h1);
        addr = 32'h7f00; @(negedge clk);
        chk("partial_ctrl_ignored", rdata, 32'h0);
        wr(32'h7f04, 32'h99, 4'h7);
        addr = 32'h7f04; @(negedge clk);
        chk("partial_preset_ignored", rdata, 32'd5);

        // Reset while TC0 COUNT = 3 (PRESET 10, COUNT 3 after edge W+9).
        wr(32'h7f04, 32'd10, 4'hf);
        wr(32'h7f00, 32'h9, 4'hf);
        addr = 32'h7f08;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("tc0_count_before_reset", rdata, 32'd3);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        chk("tc0_count_after_reset", rdata, 32'd0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk($sformatf("no_irq_after_reset_%0d", k), {26'd0, hwint}, 32'h0);
        end
        addr = 32'h7f00; #1;
        chk("tc0_ctrl_after_reset", rdata, 32'h0);

        // External IRQ is combinational; int_ack lasts exactly the write cycle.
        ext_irq = 1'b1; #1;
        chk("ext_irq_hwint", {26'd0, hwint}, 32'h4);
        ext_irq = 1'b0;
        @(negedge clk);
        addr = 32'h7f20; byteen = 4'hf; #1;
        chk("int_ack_during_write", {31'd0, int_ack}, 32'd1);
        @(posedge clk); #1 byteen = 4'h0;
        @(negedge clk);
        chk("int_ack_after_write", {31'd0, int_ack}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
